// File: rtl/proc_ctrl.sv
// proc_ctrl: control FSM sequencing the 9-bit processor datapath (R0..R7, A, G, IR, add/sub, bus mux)
//
// Optional feature: define PROC_CTRL_MVNZ_EN to decode opcode 100 as MVNZ
// (move Y to X only when G != 0); otherwise opcode 100 is illegal and GNZ is ignored.
//
// Ports:
//   Clock     in   system clock, rising edge
//   Resetn    in   asynchronous active-low reset
//   Run       in   start request, sampled only in T0
//   IR[8:0]   in   instruction: [8:6] opcode, [5:3] X, [2:0] Y
//   GNZ       in   G register is non-zero (MVNZ only)
//   IRin      out  IR load enable
//   Rin[7:0]  out  one-hot register load enable
//   Ain       out  A load enable
//   Gin       out  G load enable
//   AddSub    out  ALU op, 0 add / 1 subtract
//   BusSel    out  bus source: 0..7 Rk, 8 DIN, 9 G
//   Done      out  instruction completes this cycle
//   Step      out  current step T0..T3
//   InstrCnt  out  retired-instruction count (wraps)
module proc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [8:0]       IR,
    input  logic             GNZ,
    output logic             IRin,
    output logic [7:0]       Rin,
    output logic             Ain,
    output logic             Gin,
    output logic             AddSub,
    output logic [3:0]       BusSel,
    output logic             Done,
    output logic [1:0]       Step,
    output logic [CNT_W-1:0] InstrCnt
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [3:0] SEL_DIN = 4'b1000;
    localparam logic [3:0] SEL_G   = 4'b1001;

    step_t       state, state_nx;
    logic [2:0]  op;
    logic [3:0]  sel_x, sel_y;
    logic [7:0]  x_hot;
    logic        is_alu;

    assign op     = IR[8:6];
    assign sel_x  = {1'b0, IR[5:3]};
    assign sel_y  = {1'b0, IR[2:0]};
    assign x_hot  = 8'b1 << IR[5:3];
    assign is_alu = (op == OP_ADD) || (op == OP_SUB);
    assign Step   = state;

`ifndef PROC_CTRL_MVNZ_EN
    logic unused_gnz;
    assign unused_gnz = GNZ;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= T0;
            InstrCnt <= '0;
        end else begin
            state <= state_nx;
            if (Done)
                InstrCnt <= InstrCnt + CNT_W'(1);
        end
    end

    // Unexpected step/opcode combinations fall through to the defaults: no enables, back to T0.
    always_comb begin
        state_nx = T0;
        IRin     = 1'b0;
        Rin      = 8'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        AddSub   = 1'b0;
        BusSel   = SEL_DIN;
        Done     = 1'b0;
        case (state)
            T0: begin
                // Gated by Resetn so no IR load is requested while reset is held.
                IRin     = Run & Resetn;
                state_nx = Run ? T1 : T0;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        BusSel = sel_y;
                        Rin    = x_hot;
                        Done   = 1'b1;
                    end
                    OP_MVI: begin
                        Rin  = x_hot;
                        Done = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        BusSel   = sel_x;
                        Ain      = 1'b1;
                        state_nx = T2;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    3'b100: begin
                        BusSel = GNZ ? sel_y : SEL_DIN;
                        Rin    = GNZ ? x_hot : 8'b0;
                        Done   = 1'b1;
                    end
`endif
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                if (is_alu) begin
                    BusSel   = sel_y;
                    Gin      = 1'b1;
                    AddSub   = (op == OP_SUB);
                    state_nx = T3;
                end
            end
            T3: begin
                if (is_alu) begin
                    BusSel = SEL_G;
                    Rin    = x_hot;
                    Done   = 1'b1;
                end
            end
            default: state_nx = T0;
        endcase
    end
endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: scoreboard bench for proc_ctrl; per-cycle expected outputs queued at drive time, compared at negedge
module tb_proc_ctrl;
    localparam int CW = 4;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          Run = 1'b0;
    logic [8:0]    IR = 9'b0;
    logic          GNZ = 1'b0;
    logic          IRin, Ain, Gin, AddSub, Done;
    logic [7:0]    Rin;
    logic [3:0]    BusSel;
    logic [1:0]    Step;
    logic [CW-1:0] InstrCnt;

    proc_ctrl #(.CNT_W(CW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .GNZ(GNZ),
        .IRin(IRin), .Rin(Rin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
        .BusSel(BusSel), .Done(Done), .Step(Step), .InstrCnt(InstrCnt)
    );

    always #5 Clock = ~Clock;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [18:0]   sb_q[$];
    string         tag_q[$];
    logic [CW-1:0] cnt_exp = '0;
    wire  [18:0]   obs = {IRin, Rin, Ain, Gin, AddSub, BusSel, Done, Step};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] ev(input logic irin, input logic [7:0] rin, input logic ain,
                                       input logic gin, input logic addsub, input logic [3:0] bus,
                                       input logic done, input logic [1:0] step);
        return {irin, rin, ain, gin, addsub, bus, done, step};
    endfunction

    always @(negedge Clock) begin
        if (sb_q.size() > 0) begin
            string       t;
            logic [18:0] e;
            t = tag_q.pop_front();
            e = sb_q.pop_front();
            check(t, {13'b0, obs}, {13'b0, e});
        end
    end

    task automatic cyc(input logic run, input logic [8:0] ir, input logic gnz,
                       input logic [18:0] e, input string tag);
        Run = run;
        IR  = ir;
        GNZ = gnz;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 9'b0, 1'b0, ev(0, 8'h00, 0, 0, 0, 4'd8, 0, 2'd0), "idle");
    endtask

    // Expected sequence built from the instruction semantics: T0 fetch, then per-opcode steps.
    task automatic issue(input logic [8:0] ir, input logic gnz, input logic run_rest);
        logic [3:0] x, y;
        logic [7:0] oh;
        x  = {1'b0, ir[5:3]};
        y  = {1'b0, ir[2:0]};
        oh = 8'b1 << ir[5:3];
        cyc(1'b1, ir, gnz, ev(1, 8'h00, 0, 0, 0, 4'd8, 0, 2'd0), "t0_fetch");
        case (ir[8:6])
            3'b000: cyc(run_rest, ir, gnz, ev(0, oh, 0, 0, 0, y, 1, 2'd1), "mv_t1");
            3'b001: cyc(run_rest, ir, gnz, ev(0, oh, 0, 0, 0, 4'd8, 1, 2'd1), "mvi_t1");
            3'b010, 3'b011: begin
                cyc(run_rest, ir, gnz, ev(0, 8'h00, 1, 0, 0, x, 0, 2'd1), "alu_t1");
                cyc(run_rest, ir, gnz, ev(0, 8'h00, 0, 1, ir[8:6] == 3'b011, y, 0, 2'd2), "alu_t2");
                cyc(run_rest, ir, gnz, ev(0, oh, 0, 0, 0, 4'd9, 1, 2'd3), "alu_t3");
            end
`ifdef PROC_CTRL_MVNZ_EN
            3'b100: cyc(run_rest, ir, gnz, gnz ? ev(0, oh, 0, 0, 0, y, 1, 2'd1)
                                               : ev(0, 8'h00, 0, 0, 0, 4'd8, 1, 2'd1), "mvnz_t1");
`endif
            default: cyc(run_rest, ir, gnz, ev(0, 8'h00, 0, 0, 0, 4'd8, 1, 2'd1), "illegal_t1");
        endcase
        cnt_exp++;
    endtask

    initial begin
        logic [2:0] ops [5];
        ops = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b111};
        #12;
        check("reset_outputs", {13'b0, obs}, {13'b0, ev(0, 8'h00, 0, 0, 0, 4'd8, 0, 2'd0)});
        check("reset_cnt", {28'b0, InstrCnt}, 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        idle(5);
        check("idle_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});

        issue(9'b001_010_000, 1'b0, 1'b0);
        check("mvi_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});
        issue(9'b011_001_010, 1'b0, 1'b0);
        check("sub_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});
        idle(1);

        // Back-to-back with Run held high: MV R0,R7 then ADD R5,R5.
        issue(9'b000_000_111, 1'b0, 1'b1);
        issue(9'b010_101_101, 1'b0, 1'b1);
        idle(1);
        check("b2b_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});

        issue(9'b000_011_011, 1'b0, 1'b0);
        issue(9'b100_011_001, 1'b1, 1'b0);
        issue(9'b100_011_001, 1'b0, 1'b0);
        check("mvnz_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});

        // Enough legal/illegal short instructions to wrap the narrow counter.
        for (int i = 0; i < 18; i++) begin
            issue({ops[$urandom_range(0, 4)], 3'($urandom), 3'($urandom)}, 1'($urandom), 1'($urandom));
            check("wrap_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});
        end
        idle(1);

        // Reset asserted during T2 of ADD R1,R1.
        cyc(1'b1, 9'b010_001_001, 1'b0, ev(1, 8'h00, 0, 0, 0, 4'd8, 0, 2'd0), "rst_t0");
        cyc(1'b0, 9'b010_001_001, 1'b0, ev(0, 8'h00, 1, 0, 0, 4'd1, 0, 2'd1), "rst_t1");
        sb_q.push_back(ev(0, 8'h00, 0, 1, 0, 4'd1, 0, 2'd2));
        tag_q.push_back("rst_t2");
        @(negedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check("rst_async_step", {30'b0, Step}, 32'd0);
        check("rst_async_gin", {31'b0, Gin}, 32'd0);
        check("rst_async_rin", {24'b0, Rin}, 32'd0);
        check("rst_async_cnt", {28'b0, InstrCnt}, 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        cnt_exp = '0;
        idle(3);
        check("post_rst_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});
        issue(9'b010_010_010, 1'b0, 1'b0);
        check("post_rst_add_cnt", {28'b0, InstrCnt}, {28'b0, cnt_exp});
        idle(1);
        @(negedge Clock);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit FSM that sequences the 9-bit processor datapath: register file R0..R7, A, G, IR, the add/sub unit and the bus multiplexer.
- Decodes the instruction held in IR (format III XXX YYY) and drives, per step T0..T3, the register load enables, the bus-source select, the ALU operation select and Done.
- Also keeps a retired-instruction counter for debug.
- Sits beside the datapath inside the processor top; it contains no data registers of its own.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Run  in  1  start request; sampled only in T0.
- IR  in  9  current instruction register contents; IR[8:6] opcode, IR[5:3] X, IR[2:0] Y.
- GNZ  in  1  high when G register != 0 (used only with optional feature).
- IRin  out  1  IR load enable (IR captures DIN).
- Rin  out  8  one-hot register load enable, bit k -> Rk.
- Ain  out  1  A load enable.
- Gin  out  1  G load enable.
- AddSub  out  1  ALU op: 0 add, 1 subtract.
- BusSel  out  4  bus source: 0..7 = Rk, 4'b1000 = DIN, 4'b1001 = G.
- Done  out  1  instruction completes this cycle.
- Step  out  2  current step (T0=0..T3=3).
- InstrCnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset is asynchronous on Resetn low. Step=T0, InstrCnt=0. All enables and Done are 0, AddSub=0, BusSel=4'b1000.
- Reset mid-instruction aborts the instruction with no further writes.
- Step register is the only FSM state. All other outputs are a combinational Moore decode of Step and IR; no outputs depend on Run except IRin.
- Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 MVNZ (optional feature). All others are illegal.
- T0:
  - Run=0: remain in T0; all enables 0.
  - Run=1: IRin=1; next T1.
- T1:
  - MV: BusSel=Y, Rin[X]=1, Done=1; next T0.
  - MVI: BusSel=4'b1000, Rin[X]=1, Done=1; next T0.
  - ADD/SUB: BusSel=X, Ain=1; next T2.
  - Illegal: Done=1, no enables; next T0.
- T2 (ADD/SUB): BusSel=Y, Gin=1, AddSub = 0 for ADD, 1 for SUB; next T3.
- T3 (ADD/SUB): BusSel=4'b1001, Rin[X]=1, Done=1; next T0.
- Latency in cycles including T0: MV/MVI 2, ADD/SUB 4.
- Done is high for exactly one cycle per instruction.
- InstrCnt increments on every rising edge where Done=1, including illegal opcodes, and wraps from 2^CNT_W-1 to 0.
- Run is ignored outside T0. Run held high issues back-to-back instructions with no idle cycle.
- X=Y is legal. MV R3,R3 writes R3 with itself; ADD R2,R2 doubles R2.
- Rin is never multi-hot; at most one of IRin, Ain, Gin, any Rin bit is high in a cycle.
- If IR reaches an unexpected step (e.g. MV in T2), drive no enables and return to T0.

Optional Feature:
- Macro PROC_CTRL_MVNZ_EN.
- Defined: opcode 100 = MVNZ.
  - T1: Done=1; next T0.
  - If GNZ=1: BusSel=Y, Rin[X]=1.
  - If GNZ=0: no enables.
- Undefined: opcode 100 is illegal (Done in T1, no writes); GNZ is ignored.

Test Plan:
- Reset low then release, Run=0 for 5 cycles -> Step=0, Done=0, InstrCnt=0, BusSel=4'b1000, all enables 0 throughout.
- Run=1 in T0, IR=9'b001_010_000 (MVI R2) -> cycle T0: IRin=1. Cycle T1: BusSel=4'b1000, Rin=8'b0000_0100, Done=1. Then InstrCnt=1.
- IR=9'b011_001_010 (SUB R1,R2) ->
  - T1: BusSel=1, Ain=1.
  - T2: BusSel=2, Gin=1, AddSub=1.
  - T3: BusSel=9, Rin=8'b0000_0010, Done=1.
  - Step sequence 0,1,2,3,0.
- Run held high over MV R0,R7 then ADD R5,R5 -> Done pulses at cycles 2 and 6; no idle T0 cycle between instructions; InstrCnt=2.
- Resetn pulsed low during T2 of an ADD -> Step=0 immediately, Gin drops asynchronously, no Rin pulse follows, InstrCnt=0.
- IR=9'b100_011_001 with GNZ=1, then with GNZ=0:
  - With PROC_CTRL_MVNZ_EN: Rin=8'b0000_1000 for GNZ=1; Rin=0 with Done=1 for GNZ=0.
  - Without it: Done=1 and Rin=0 in both cases.
